// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: register hazards at D, MDU busy tracking, stall counter.
// Latency: stall and enables are combinational in the same cycle; md_busy is registered (starts the cycle after issue).
// Backpressure: a stall freezes PC and F/D and inserts a bubble into D/E; E and M always advance.
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic [1:0]       D_tuse_rs,
    input  logic [1:0]       D_tuse_rt,
    input  logic             D_md_use,
    input  logic [4:0]       E_wreg,
    input  logic [1:0]       E_tnew,
    input  logic [4:0]       M_wreg,
    input  logic [1:0]       M_tnew,
    input  logic             E_md_start,
    input  logic             E_md_is_div,
    output logic             F_en,
    output logic             FD_en,
    output logic             DE_en,
    output logic             DE_refresh,
    output logic             EM_en,
    output logic             EM_refresh,
    output logic             md_busy,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int BC_W    = $clog2(MAX_LAT + 1);

    // Encoding is fixed so the state can be observed as a plain 2-bit value.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [BC_W-1:0]  busy_cnt_q, busy_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_hazard, rt_hazard, md_hazard;

    // A source register is a hazard only if it is live (non-zero, used) and the
    // producer in E or M cannot deliver it in time to be forwarded.
    always_comb begin
        rs_hazard = (D_rs != 5'd0) && (D_tuse_rs != 2'd3) &&
                    (((E_wreg == D_rs) && (E_tnew > D_tuse_rs)) ||
                     ((M_wreg == D_rs) && (M_tnew > D_tuse_rs)));
        rt_hazard = (D_rt != 5'd0) && (D_tuse_rt != 2'd3) &&
                    (((E_wreg == D_rt) && (E_tnew > D_tuse_rt)) ||
                     ((M_wreg == D_rt) && (M_tnew > D_tuse_rt)));
        md_hazard = D_md_use && (E_md_start || md_busy);
        stall     = rs_hazard || rt_hazard || md_hazard;
    end

    // Pipeline register controls: hold front end and bubble D/E on a stall.
    always_comb begin
        F_en       = !stall;
        FD_en      = !stall;
        DE_en      = 1'b1;
        DE_refresh = stall;
        EM_en      = 1'b1;
        EM_refresh = 1'b0;
    end

    assign md_busy   = (state_q != IDLE);
    assign stall_cnt = stall_cnt_q;

    // MDU busy scheduler: a new start always reloads (latest request wins);
    // otherwise count down and go idle after the last busy cycle.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        if (E_md_start) begin
            state_d    = E_md_is_div ? DIV_BUSY : MUL_BUSY;
            busy_cnt_d = E_md_is_div ? BC_W'(DIV_LAT) : BC_W'(MULT_LAT);
        end else if (state_q != IDLE) begin
            if (busy_cnt_q == BC_W'(1)) begin
                state_d    = IDLE;
                busy_cnt_d = '0;
            end else begin
                busy_cnt_d = busy_cnt_q - BC_W'(1);
            end
        end
    end

    // Stall performance counter, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset overrides any start request or stall in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a 4-bit stall counter.
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
// Expected values are hand-computed constants plus a small saturating counter model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       D_rs, D_rt, E_wreg, M_wreg;
    logic [1:0]       D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic             D_md_use, E_md_start, E_md_is_div;
    logic             F_en, FD_en, DE_en, DE_refresh, EM_en, EM_refresh;
    logic             md_busy, stall;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_md_use(D_md_use), .E_wreg(E_wreg), .E_tnew(E_tnew),
        .M_wreg(M_wreg), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .F_en(F_en), .FD_en(FD_en), .DE_en(DE_en), .DE_refresh(DE_refresh),
        .EM_en(EM_en), .EM_refresh(EM_refresh),
        .md_busy(md_busy), .stall(stall), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check stall and the full set of pipeline register controls together.
    task automatic chk_ctrl(input string tag, input logic exp_stall);
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        chk({tag, ".ctrl"},
            32'({F_en, FD_en, DE_en, DE_refresh, EM_en, EM_refresh}),
            exp_stall ? 32'b001110 : 32'b111010);
    endtask

    // Advance one clock, updating the counter model with this cycle's expected stall.
    task automatic adv(input logic exp_stall);
        @(posedge clk);
        if (reset) exp_cnt = 0;
        else if (exp_stall && exp_cnt != 15) exp_cnt++;
        #1;
    endtask

    task automatic clear_inputs();
        D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_md_use = 0;
        E_wreg = 0; E_tnew = 0; M_wreg = 0; M_tnew = 0;
        E_md_start = 0; E_md_is_div = 0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        adv(0);
        adv(0);
        reset = 1'b0;
        chk_ctrl("reset", 0);
        chk("reset.md_busy", 32'(md_busy), 0);
        chk("reset.stall_cnt", 32'(stall_cnt), 0);

        // Load-use on rs from E, then from M, then resolved.
        D_rs = 8; D_tuse_rs = 0; E_wreg = 8; E_tnew = 2;
        chk_ctrl("loaduse_E", 1);
        adv(1);
        E_wreg = 0; E_tnew = 0; M_wreg = 8; M_tnew = 1;
        chk_ctrl("loaduse_M", 1);
        adv(1);
        M_tnew = 0;
        chk_ctrl("loaduse_done", 0);
        adv(0);
        chk("loaduse.stall_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // rt hazard from M.
        clear_inputs();
        D_rt = 9; D_tuse_rt = 1; M_wreg = 9; M_tnew = 2;
        chk_ctrl("rt_M", 1);
        adv(1);

        // Register 0, unused operand, and forwardable (tnew == tuse) cases.
        clear_inputs();
        D_rs = 0; D_tuse_rs = 0; E_wreg = 0; E_tnew = 2;
        chk_ctrl("zero_reg", 0);
        clear_inputs();
        D_rt = 5; D_tuse_rt = 3; E_wreg = 5; E_tnew = 2;
        chk_ctrl("rt_unused", 0);
        clear_inputs();
        D_rs = 7; D_tuse_rs = 1; E_wreg = 7; E_tnew = 1;
        chk_ctrl("forwardable", 0);
        adv(0);
        chk("misc.stall_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // Mult: start in cycle 0, busy cycles 1..5, idle in cycle 6.
        clear_inputs();
        E_md_start = 1; E_md_is_div = 0; D_md_use = 1;
        chk_ctrl("mul_c0", 1);
        chk("mul_c0.md_busy", 32'(md_busy), 0);
        adv(1);
        E_md_start = 0;
        for (int c = 1; c <= 5; c++) begin
            chk_ctrl($sformatf("mul_c%0d", c), 1);
            chk($sformatf("mul_c%0d.md_busy", c), 32'(md_busy), 1);
            if (c == 1) chk("mul.state", 32'(dut.state_q), 1);
            adv(1);
        end
        chk_ctrl("mul_c6", 0);
        chk("mul_c6.md_busy", 32'(md_busy), 0);
        adv(0);
        chk("mul.stall_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // Div with a second start in busy cycle 3: busy cycles 4..13 follow.
        clear_inputs();
        E_md_start = 1; E_md_is_div = 1;
        adv(0);
        E_md_start = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) E_md_start = 1;
            #1;
            chk($sformatf("div_c%0d.md_busy", c), 32'(md_busy), 1);
            adv(0);
        end
        E_md_start = 0;
        for (int c = 4; c <= 13; c++) begin
            D_md_use = (c == 8);
            chk_ctrl($sformatf("div_c%0d", c), (c == 8));
            chk($sformatf("div_c%0d.md_busy", c), 32'(md_busy), 1);
            if (c == 13) chk("div.state", 32'(dut.state_q), 2);
            adv(c == 8);
        end
        D_md_use = 0;
        #1;
        chk("div_c14.md_busy", 32'(md_busy), 0);
        chk("div.stall_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // Reset in busy cycle 4 of a div abandons it and clears the counter.
        clear_inputs();
        E_md_start = 1; E_md_is_div = 1;
        adv(0);
        E_md_start = 0;
        for (int c = 1; c <= 3; c++) adv(0);
        D_md_use = 1; reset = 1;
        chk_ctrl("rst_mid_div", 1);
        adv(1);
        reset = 0;
        chk_ctrl("after_rst", 0);
        chk("after_rst.md_busy", 32'(md_busy), 0);
        chk("after_rst.stall_cnt", 32'(stall_cnt), 0);

        // Start request coinciding with reset is dropped.
        D_md_use = 0; E_md_start = 1; E_md_is_div = 0; reset = 1;
        adv(0);
        reset = 0; E_md_start = 0;
        #1;
        chk("rst_vs_start.md_busy", 32'(md_busy), 0);

        // Hold an rs hazard for 20 cycles: counter saturates at 15.
        clear_inputs();
        D_rs = 8; D_tuse_rs = 0; E_wreg = 8; E_tnew = 2;
        for (int i = 1; i <= 20; i++) begin
            adv(1);
            if (i == 14) chk("sat_14", 32'(stall_cnt), 14);
            if (i == 15) chk("sat_15", 32'(stall_cnt), 15);
            if (i == 20) chk("sat_20", 32'(stall_cnt), 15);
        end
        chk("sat.model", 32'(stall_cnt), 32'(exp_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
